// File: rtl/uart_rx_cfg_ctrl_if.sv
// Host/receiver-side signal bundle for uart_rx_cfg_ctrl.
// The slave modport is the controller; the master modport drives its inputs.
interface uart_rx_cfg_ctrl_if;
   logic       cfg_wr_i;
   logic [1:0] cfg_data_width_i;
   logic [1:0] cfg_stop_bits_i;
   logic [1:0] cfg_parity_i;
   logic       config_req_slv_i;
   logic       rx_fifo_empty_i;
   logic [7:0] data_rx_i;
   logic       req_ackn_o;
   logic       rx_fifo_read_o;
   logic [1:0] data_width_o;
   logic [1:0] stop_bits_number_o;
   logic [1:0] parity_mode_o;
   logic       cfg_busy_o;
   logic       cfg_done_o;
   logic       cfg_error_o;
   logic       host_wr_drop_o;
   logic [2:0] cfg_state_dbg;

   modport slave (
      input  cfg_wr_i, cfg_data_width_i, cfg_stop_bits_i, cfg_parity_i,
      input  config_req_slv_i, rx_fifo_empty_i, data_rx_i,
      output req_ackn_o, rx_fifo_read_o, data_width_o, stop_bits_number_o,
      output parity_mode_o, cfg_busy_o, cfg_done_o, cfg_error_o, host_wr_drop_o,
      output cfg_state_dbg
   );

   modport master (
      output cfg_wr_i, cfg_data_width_i, cfg_stop_bits_i, cfg_parity_i,
      output config_req_slv_i, rx_fifo_empty_i, data_rx_i,
      input  req_ackn_o, rx_fifo_read_o, data_width_o, stop_bits_number_o,
      input  parity_mode_o, cfg_busy_o, cfg_done_o, cfg_error_o, host_wr_drop_o,
      input  cfg_state_dbg
   );
endinterface

// File: rtl/uart_rx_cfg_ctrl.sv
// UART receiver line-config registers plus the remote config handshake sequencer.
// Optional WAIT_BYTE timeout is built when CFG_TIMEOUT_EN is defined.
module uart_rx_cfg_ctrl #(
   parameter logic [1:0]  RST_DATA_WIDTH = 2'b11,
   parameter logic [1:0]  RST_STOP_BITS  = 2'b00,
   parameter logic [1:0]  RST_PARITY     = 2'b00,
   parameter logic [1:0]  CFG_SIGNATURE  = 2'b10,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input logic               clk_i,
   input logic               rst_i,
   uart_rx_cfg_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ACK       = 3'd1,
      ST_WAIT_BYTE = 3'd2,
      ST_POP       = 3'd3,
      ST_CHECK     = 3'd4
   } state_t;

   state_t state_q;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

`ifdef CFG_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q;
`endif

   assign bus.cfg_busy_o     = (state_q != ST_IDLE);
   assign bus.host_wr_drop_o = bus.cfg_wr_i && (state_q != ST_IDLE) && !rst_i;
   assign bus.cfg_state_dbg  = state_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q                <= ST_IDLE;
         bus.data_width_o       <= RST_DATA_WIDTH;
         bus.stop_bits_number_o <= RST_STOP_BITS;
         bus.parity_mode_o      <= RST_PARITY;
         bus.req_ackn_o         <= 1'b0;
         bus.rx_fifo_read_o     <= 1'b0;
         bus.cfg_done_o         <= 1'b0;
         bus.cfg_error_o        <= 1'b0;
`ifdef CFG_TIMEOUT_EN
         wait_cnt_q             <= '0;
`endif
      end else begin
         bus.req_ackn_o     <= 1'b0;
         bus.rx_fifo_read_o <= 1'b0;
         bus.cfg_done_o     <= 1'b0;
         bus.cfg_error_o    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.cfg_wr_i) begin
                  bus.data_width_o       <= bus.cfg_data_width_i;
                  bus.stop_bits_number_o <= bus.cfg_stop_bits_i;
                  bus.parity_mode_o      <= bus.cfg_parity_i;
               end
               if (bus.config_req_slv_i) begin
                  state_q        <= ST_ACK;
                  bus.req_ackn_o <= 1'b1;
               end
            end
            ST_ACK: begin
               state_q <= ST_WAIT_BYTE;
`ifdef CFG_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            ST_WAIT_BYTE: begin
               if (!bus.rx_fifo_empty_i) begin
                  state_q            <= ST_POP;
                  bus.rx_fifo_read_o <= 1'b1;
               end
`ifdef CFG_TIMEOUT_EN
               else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q         <= ST_IDLE;
                  bus.cfg_error_o <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end
            ST_POP: begin
               // The byte is validated as it is captured so the new config and
               // the done/error pulse are both visible during CHECK.
               state_q <= ST_CHECK;
               if (bus.data_rx_i[7:6] == CFG_SIGNATURE) begin
                  bus.data_width_o       <= bus.data_rx_i[1:0];
                  bus.stop_bits_number_o <= bus.data_rx_i[3:2];
                  bus.parity_mode_o      <= bus.data_rx_i[5:4];
                  bus.cfg_done_o         <= 1'b1;
               end else begin
                  bus.cfg_error_o <= 1'b1;
               end
            end
            ST_CHECK: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
